pixel_stream_demux2: RTL and testbench

- Splits one pixel stream into two channels by pixel parity: even pixel index to channel 0, odd pixel index to channel 1.
- This is the inverse of the team's two-input selector. It feeds dual-lane downstream filters that each process half of the pixels on a line.
- Each output lane has a 2-entry FIFO, so one lane can stall without blocking the other until the stalled lane's FIFO fills.
- All handshakes are valid/ready.

---
 rtl/pixel_stream_demux2.sv | 160 ++++++++++++++++
 tb/tb_pixel_stream_demux2.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_demux2.sv
// pixel_stream_demux2
//
// Purpose: splits one valid/ready pixel stream into two lanes by pixel
// parity within a line. Even pixel indices go to lane 0 and odd indices to
// lane 1. Every line restarts on lane 0, whatever its length. Each lane
// has its own 2-entry first-word-fall-through FIFO. A stalled lane
// therefore only blocks the input once its FIFO is full and the next
// pixel targets it.
//
// Optional feature (macro DEMUX_CNT_EN): adds per-lane delivered-beat
// counters ch0_count / ch1_count. Each is CNT_W bits wide and wraps modulo
// 2^CNT_W.
//
// Ports:
//   clk                 sole clock, rising edge
//   rst                 synchronous active-high reset
//   in_data/valid/last  input pixel stream (last marks end of line)
//   in_ready            input beat accepted this cycle
//   chN_data/last       head entry of lane N FIFO (held when empty)
//   chN_valid           lane N FIFO non-empty
//   chN_ready           lane N consumer accepts
//   chN_count           beats popped from lane N (DEMUX_CNT_EN only)

module pixel_stream_demux2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
`ifdef DEMUX_CNT_EN
  output logic [CNT_W-1:0]  ch0_count,
  output logic [CNT_W-1:0]  ch1_count,
`endif
  output logic [DATA_W-1:0] ch0_data,
  output logic              ch0_valid,
  output logic              ch0_last,
  input  logic              ch0_ready,
  output logic [DATA_W-1:0] ch1_data,
  output logic              ch1_valid,
  output logic              ch1_last,
  input  logic              ch1_ready
);

  // Target lane for the next accepted beat
  logic r_sel;

  logic [DATA_W:0]   w_entry;
  logic              w_accept;
  logic [1:0]        w_full;
  logic [1:0]        w_valid;
  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic [1:0]        w_out_ready;
  logic [1:0]        w_last;
  logic [DATA_W-1:0] w_data [2];
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0]  w_count [2];
`endif

  assign w_entry     = {in_last, in_data};
  assign w_out_ready = {ch1_ready, ch0_ready};

  // Only the registered fullness of the target lane gates the input. A pop
  // in the same cycle does not open a slot, so ready never depends
  // combinationally on the consumers.
  assign in_ready = !rst && !w_full[r_sel];
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= 1'b0;
    end else if (w_accept) begin
      r_sel <= in_last ? 1'b0 : ~r_sel;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      // Head is what the consumer sees. Tail holds the second entry only.
      logic [DATA_W:0] r_head;
      logic [DATA_W:0] r_tail;
      logic [1:0]      r_cnt;

      assign w_push[gi]  = w_accept && (r_sel == (gi == 1));
      assign w_full[gi]  = (r_cnt == 2'd2);
      assign w_valid[gi] = !rst && (r_cnt != 2'd0);
      assign w_pop[gi]   = w_valid[gi] && w_out_ready[gi];
      assign w_data[gi]  = r_head[DATA_W-1:0];
      assign w_last[gi]  = r_head[DATA_W];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_head <= '0;
          r_tail <= '0;
          r_cnt  <= 2'd0;
        end else begin
          case ({w_push[gi], w_pop[gi]})
            2'b10: begin
              if (r_cnt == 2'd0) begin
                r_head <= w_entry;
                r_cnt  <= 2'd1;
              end else begin
                r_tail <= w_entry;
                r_cnt  <= 2'd2;
              end
            end
            2'b01: begin
              if (r_cnt == 2'd2) begin
                r_head <= r_tail;
                r_cnt  <= 2'd1;
              end else begin
                // Head keeps its value so the data outputs hold when empty
                r_cnt  <= 2'd0;
              end
            end
            2'b11: begin
              // A push needs count<2 and a pop needs count>0, so count is
              // 1 here. The pushed entry replaces the departing head.
              r_head <= w_entry;
            end
            default: begin
            end
          endcase
        end
      end

`ifdef DEMUX_CNT_EN
      logic [CNT_W-1:0] r_count;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_count <= '0;
        end else if (w_pop[gi]) begin
          r_count <= r_count + CNT_W'(1);
        end
      end

      assign w_count[gi] = r_count;
`endif
    end
  endgenerate

  assign ch0_data  = w_data[0];
  assign ch0_last  = w_last[0];
  assign ch0_valid = w_valid[0];
  assign ch1_data  = w_data[1];
  assign ch1_last  = w_last[1];
  assign ch1_valid = w_valid[1];

`ifdef DEMUX_CNT_EN
  assign ch0_count = w_count[0];
  assign ch1_count = w_count[1];
`endif

endmodule

// File: tb/tb_pixel_stream_demux2.sv
// Testbench for pixel_stream_demux2. A negedge monitor keeps a per-lane
// scoreboard: accepted input beats are pushed to the lane the parity rule
// selects, and each lane pop is compared against the queue front.
// Scenario tasks drive stimulus and check handshake and boundary behaviour
// inline.

module tb_pixel_stream_demux2;

  localparam int DATA_W = 8;
`ifdef DEMUX_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] ch0_data, ch1_data;
  logic              ch0_valid, ch1_valid, ch0_last, ch1_last;
  logic              ch0_ready = 1'b0;
  logic              ch1_ready = 1'b0;
`ifdef DEMUX_CNT_EN
  logic [TB_CNT_W-1:0] ch0_count, ch1_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b1;

  logic [DATA_W:0] q0[$];
  logic [DATA_W:0] q1[$];
  logic            m_sel = 1'b0;

  always #5 clk = ~clk;

  pixel_stream_demux2 #(.DATA_W(DATA_W), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
`ifdef DEMUX_CNT_EN
    .ch0_count(ch0_count), .ch1_count(ch1_count),
`endif
    .ch0_data(ch0_data), .ch0_valid(ch0_valid), .ch0_last(ch0_last), .ch0_ready(ch0_ready),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_last(ch1_last), .ch1_ready(ch1_ready)
  );

  // Scoreboard monitor: samples the handshakes that complete at the next edge
  always @(negedge clk) begin
    logic [DATA_W:0] exp_e;
    if (mon_en) begin
      if (rst) begin
        q0.delete();
        q1.delete();
        m_sel = 1'b0;
      end else begin
        if (ch0_valid && ch0_ready) begin
          n_checks++;
          if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL lane0_pop: unexpected pop data=%h last=%b, required no pop", ch0_data, ch0_last);
          end else begin
            exp_e = q0.pop_front();
            if ({ch0_last, ch0_data} !== exp_e) begin
              n_fail++;
              $display("FAIL lane0_pop: got last=%b data=%h, required last=%b data=%h",
                       ch0_last, ch0_data, exp_e[DATA_W], exp_e[DATA_W-1:0]);
            end
          end
        end
        if (ch1_valid && ch1_ready) begin
          n_checks++;
          if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL lane1_pop: unexpected pop data=%h last=%b, required no pop", ch1_data, ch1_last);
          end else begin
            exp_e = q1.pop_front();
            if ({ch1_last, ch1_data} !== exp_e) begin
              n_fail++;
              $display("FAIL lane1_pop: got last=%b data=%h, required last=%b data=%h",
                       ch1_last, ch1_data, exp_e[DATA_W], exp_e[DATA_W-1:0]);
            end
          end
        end
        if (in_valid && in_ready) begin
          $display("accept data=%h last=%b -> lane %0d", in_data, in_last, m_sel);
          if (m_sel) q1.push_back({in_last, in_data});
          else       q0.push_back({in_last, in_data});
          m_sel = in_last ? 1'b0 : ~m_sel;
        end
      end
    end
  end

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input logic [DATA_W-1:0] d, input logic l);
    logic ir;
    bit   done = 1'b0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      ir = in_ready;
      @(posedge clk);
      #1;
      if (ir) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: beat %h not accepted, required acceptance within 40 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain_check(input string name);
    ch0_ready = 1'b1;
    ch1_ready = 1'b1;
    idle(6);
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: pending lane0=%0d lane1=%0d, required 0 and 0", name, q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    end
    n_checks++;
    if ({ch0_valid, ch1_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_valid: got %b%b, required 00", ch1_valid, ch0_valid);
    end
    n_checks++;
    if ({ch0_last, ch0_data, ch1_last, ch1_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got ch0=%b/%h ch1=%b/%h, required all 0", ch0_last, ch0_data, ch1_last, ch1_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    logic ir;
    ch0_ready = 1'b1;
    ch1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data  = 8'h10 + DATA_W'(i);
      in_last  = (i == 7);
      in_valid = 1'b1;
      @(negedge clk);
      ir = in_ready;
      n_checks++;
      if (ir !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_in_ready: beat %0d got %b, required 1", i, ir);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain_check("stream");
  endtask

  task automatic test_odd_line();
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    send(8'hB0, 1'b0);
    // B0 must appear on lane 0 one cycle after acceptance
    @(negedge clk);
    n_checks++;
    if (ch0_valid !== 1'b1 || ch0_data !== 8'hB0) begin
      n_fail++;
      $display("FAIL odd_line_restart: lane0 valid=%b data=%h, required 1/B0", ch0_valid, ch0_data);
    end
    @(posedge clk);
    #1;
    send(8'hB1, 1'b1);
    drain_check("odd_line");
  endtask

  task automatic test_backpressure();
    logic ir;
    int   acc = 0;
    ch0_ready = 1'b1;
    ch1_ready = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b0;
    in_data   = 8'h30;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ir = in_ready;
      @(posedge clk);
      #1;
      if (ir) begin
        acc++;
        in_data = 8'h30 + DATA_W'(acc);
      end
    end
    // Beats 0..4 fit (lane 1 takes 1 and 3); beat 5 targets full lane 1
    n_checks++;
    if (acc != 5) begin
      n_fail++;
      $display("FAIL bp_accepted: got %0d beats, required 5", acc);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall: in_ready got %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    ch1_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_pop_cycle: in_ready got %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_after_pop: in_ready got %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain_check("bp");
  endtask

  task automatic test_full_pop();
    ch0_ready = 1'b0;
    ch1_ready = 1'b1;
    send(8'h50, 1'b0);
    send(8'h51, 1'b0);
    send(8'h52, 1'b0);
    send(8'h53, 1'b0);
    // Lane 0 now holds two entries and is the target
    in_data   = 8'h54;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    ch0_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_same_cycle: in_ready got %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_next_cycle: in_ready got %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain_check("full_pop");
  endtask

  task automatic test_reset_midstream();
    ch0_ready = 1'b1;
    ch1_ready = 1'b0;
    send(8'h60, 1'b0);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    send(8'h64, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if ({ch0_valid, ch1_valid, in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_outputs: v0=%b v1=%b ir=%b, required 0 0 0", ch0_valid, ch1_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    n_checks++;
    if ({ch0_valid, ch1_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_after: v0=%b v1=%b, required 0 0", ch0_valid, ch1_valid);
    end
    send(8'hAA, 1'b0);
    @(negedge clk);
    n_checks++;
    if (ch0_valid !== 1'b1 || ch0_data !== 8'hAA || ch1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_lane0: v0=%b d0=%h v1=%b, required 1 AA 0", ch0_valid, ch0_data, ch1_valid);
    end
    @(posedge clk);
    #1;
    send(8'hAB, 1'b1);
    drain_check("midreset");
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counters();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    ch0_ready = 1'b1;
    ch1_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(8'h70 + DATA_W'(i), (i == 4));
    idle(3);
    n_checks++;
    if (ch0_count !== 4'd3 || ch1_count !== 4'd2) begin
      n_fail++;
      $display("FAIL cnt_five: got %0d/%0d, required 3/2", ch0_count, ch1_count);
    end
    ch1_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h80 + DATA_W'(i), 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_checks++;
    if (ch0_count !== 4'd0 || ch1_count !== 4'd0 || ch0_valid !== 1'b0 || ch1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_reset: counts %0d/%0d valids %b%b, required 0/0 00",
               ch0_count, ch1_count, ch1_valid, ch0_valid);
    end
    ch1_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(8'h90 + DATA_W'(i), 1'b1);
    idle(3);
    n_checks++;
    if (ch0_count !== 4'd1 || ch1_count !== 4'd0) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %0d/%0d, required 1/0", ch0_count, ch1_count);
    end
    drain_check("cnt");
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_odd_line();
    test_backpressure();
    test_full_pop();
    test_reset_midstream();
`ifdef DEMUX_CNT_EN
    test_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
